// File: rtl/rc_pkg.sv
// Shared encodings and default thresholds for the RC/autopilot mode controller.
package rc_pkg;

  typedef enum logic [1:0] {
    MODE_AUTO     = 2'b00,
    MODE_RC       = 2'b01,
    MODE_TO_AUTO  = 2'b10,
    MODE_FAILSAFE = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    VOTE_LOW     = 2'd0,
    VOTE_HIGH    = 2'd1,
    VOTE_ILLEGAL = 2'd2
  } vote_e;

  localparam int unsigned DEF_MIN_US    = 800;
  localparam int unsigned DEF_MAX_US    = 2200;
  localparam int unsigned DEF_HI_TH     = 1600;
  localparam int unsigned DEF_LO_TH     = 1400;
  localparam int unsigned DEF_CONFIRM   = 3;
  localparam int unsigned DEF_BAD_LIMIT = 4;
  localparam int unsigned DEF_LOSS_US   = 50000;
  localparam int unsigned DEF_ACK_US    = 20000;

  // Widths inside the hysteresis band repeat the previous legal vote.
  function automatic vote_e classify(input logic [15:0] w, input vote_e prev,
                                     input int unsigned min_us, input int unsigned max_us,
                                     input int unsigned hi_th, input int unsigned lo_th);
    int unsigned wi;
    wi = 32'(w);
    if (wi < min_us || wi > max_us) return VOTE_ILLEGAL;
    if (wi >= hi_th) return VOTE_HIGH;
    if (wi <= lo_th) return VOTE_LOW;
    return prev;
  endfunction

endpackage

// File: rtl/rc_pulse_meter.sv
// Synchronises the RC enable PWM, measures high time in pwm_clk ticks and
// flags link loss when no rising edge arrives within LOSS_US ticks.
module rc_pulse_meter
  import rc_pkg::*;
#(
  parameter int unsigned LOSS_US = DEF_LOSS_US
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_clk,
  input  logic        rc_en_in,
  output logic [15:0] pulse_width,
  output logic        width_valid,
  output logic        loss
);

  localparam int unsigned WDW = $clog2(LOSS_US + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(LOSS_US);

  logic           sync1, sync2, sync_d;
  logic           rise, fall;
  logic [15:0]    width_cnt;
  logic [WDW-1:0] wd_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      sync1  <= rc_en_in;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign rise = sync2 & ~sync_d;
  assign fall = ~sync2 & sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_cnt <= '0;
    end else if (rise) begin
      width_cnt <= '0;
    end else if (pwm_clk && sync2 && width_cnt != '1) begin
      width_cnt <= width_cnt + 16'd1;
    end
  end

  // sync2 is already low in the falling-edge cycle, so the capture never
  // races a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_width <= '0;
      width_valid <= 1'b0;
    end else begin
      width_valid <= fall;
      if (fall) pulse_width <= width_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (rise) begin
      wd_cnt <= '0;
    end else if (pwm_clk && wd_cnt != WD_MAX) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign loss = (wd_cnt == WD_MAX);

endmodule

// File: rtl/rc_mode_ctrl.sv
// Chooses RC pilot or autopilot for the servo mux from the RC enable channel,
// with pulse sanity checks, hysteresis, link-loss failsafe and CPU handover.
module rc_mode_ctrl
  import rc_pkg::*;
#(
  parameter int unsigned MIN_US    = DEF_MIN_US,
  parameter int unsigned MAX_US    = DEF_MAX_US,
  parameter int unsigned HI_TH     = DEF_HI_TH,
  parameter int unsigned LO_TH     = DEF_LO_TH,
  parameter int unsigned CONFIRM   = DEF_CONFIRM,
  parameter int unsigned BAD_LIMIT = DEF_BAD_LIMIT,
  parameter int unsigned LOSS_US   = DEF_LOSS_US,
  parameter int unsigned ACK_US    = DEF_ACK_US
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_clk,
  input  logic        rc_en_in,
  input  logic        cpu_ack,
  output logic        sel_rc,
  output logic        failsafe,
  output logic        auto_req,
  output logic        ack_err,
  output logic [1:0]  mode,
  output logic        mode_irq,
  output logic [15:0] pulse_width,
  output logic        width_valid
);

  localparam int unsigned AW  = $clog2(CONFIRM + 1);
  localparam int unsigned BW  = $clog2(BAD_LIMIT + 1);
  localparam int unsigned AKW = $clog2(ACK_US + 1);
  localparam logic [AW-1:0]  AGREE_MAX = AW'(CONFIRM);
  localparam logic [BW-1:0]  BAD_MAX   = BW'(BAD_LIMIT);
  localparam logic [AKW-1:0] ACK_MAX   = AKW'(ACK_US);

  logic           loss;
  vote_e          vote_now, prev_vote;
  logic           judge, judge_legal;
  logic [AW-1:0]  agree_cnt;
  logic [BW-1:0]  bad_cnt;
  logic [AKW-1:0] ack_cnt;
  mode_e          state_q, state_nxt;
  logic           ack_err_nxt;
  logic           bad_hit, timeout, confirm, hi_vote, lo_vote;

  rc_pulse_meter #(
    .LOSS_US(LOSS_US)
  ) u_meter (
    .clk        (clk),
    .rst_n      (rst_n),
    .pwm_clk    (pwm_clk),
    .rc_en_in   (rc_en_in),
    .pulse_width(pulse_width),
    .width_valid(width_valid),
    .loss       (loss)
  );

  assign vote_now = classify(pulse_width, prev_vote, MIN_US, MAX_US, HI_TH, LO_TH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_vote   <= VOTE_LOW;
      judge       <= 1'b0;
      judge_legal <= 1'b0;
      bad_cnt     <= '0;
    end else begin
      judge       <= width_valid;
      judge_legal <= width_valid && (vote_now != VOTE_ILLEGAL);
      if (width_valid) begin
        if (vote_now == VOTE_ILLEGAL) begin
          if (bad_cnt != BAD_MAX) bad_cnt <= bad_cnt + 1'b1;
        end else begin
          bad_cnt   <= '0;
          prev_vote <= vote_now;
        end
      end
    end
  end

  // State entry wins over a coincident pulse so every state starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      agree_cnt <= '0;
    end else if (state_nxt != state_q) begin
      agree_cnt <= '0;
    end else if (width_valid) begin
      if (vote_now == VOTE_ILLEGAL)      agree_cnt <= '0;
      else if (vote_now != prev_vote)    agree_cnt <= AW'(1);
      else if (agree_cnt != AGREE_MAX)   agree_cnt <= agree_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_cnt <= '0;
    end else if (state_q != MODE_TO_AUTO) begin
      ack_cnt <= '0;
    end else if (pwm_clk && ack_cnt != ACK_MAX) begin
      ack_cnt <= ack_cnt + 1'b1;
    end
  end

  assign bad_hit = judge && (bad_cnt == BAD_MAX);
  assign timeout = (state_q == MODE_TO_AUTO) && (ack_cnt == ACK_MAX);
  assign confirm = judge_legal && (agree_cnt == AGREE_MAX);
  assign hi_vote = judge_legal && (prev_vote == VOTE_HIGH);
  assign lo_vote = judge_legal && (prev_vote == VOTE_LOW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MODE_FAILSAFE;
      mode_irq <= 1'b0;
      ack_err  <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      mode_irq <= (state_nxt != state_q);
      ack_err  <= ack_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    ack_err_nxt = 1'b0;
    case (state_q)
      MODE_FAILSAFE: begin
        if (confirm && hi_vote)      state_nxt = MODE_RC;
        else if (confirm && lo_vote) state_nxt = MODE_AUTO;
      end
      MODE_AUTO: begin
        if (loss || bad_hit)         state_nxt = MODE_FAILSAFE;
        else if (confirm && hi_vote) state_nxt = MODE_RC;
      end
      MODE_RC: begin
        if (loss || bad_hit)         state_nxt = MODE_FAILSAFE;
        else if (confirm && lo_vote) state_nxt = MODE_TO_AUTO;
      end
      MODE_TO_AUTO: begin
        if (loss || bad_hit) begin
          state_nxt = MODE_FAILSAFE;
        end else if (cpu_ack) begin
          state_nxt = MODE_AUTO;
        end else if (timeout) begin
          state_nxt   = MODE_RC;
          ack_err_nxt = 1'b1;
        end else if (hi_vote) begin
          state_nxt = MODE_RC;
        end
      end
      default: state_nxt = MODE_FAILSAFE;
    endcase
  end

  assign mode     = state_q;
  assign sel_rc   = (state_q == MODE_RC) || (state_q == MODE_TO_AUTO);
  assign failsafe = (state_q == MODE_FAILSAFE);
  assign auto_req = (state_q == MODE_TO_AUTO);

endmodule

// File: tb/tb_rc_mode_ctrl.sv
// Directed bench for rc_mode_ctrl; time constants scaled down (1 tick = 2 clk,
// widths /20) so the whole run stays short.
`timescale 1ns/1ps
module tb_rc_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, pwm_clk, rc_en_in, cpu_ack;
  logic        sel_rc, failsafe, auto_req, ack_err, mode_irq, width_valid;
  logic [1:0]  mode;
  logic [15:0] pulse_width;

  int tests = 0, fails = 0;
  int div = 2, pcnt = 0;
  int irq_cnt = 0, ackerr_cnt = 0, wv_cnt = 0;
  int i0, a0, w0;

  localparam logic [1:0] M_AUTO = 2'b00, M_RC = 2'b01, M_TO = 2'b10, M_FS = 2'b11;

  rc_mode_ctrl #(
    .MIN_US(40), .MAX_US(110), .HI_TH(80), .LO_TH(70),
    .CONFIRM(3), .BAD_LIMIT(4), .LOSS_US(1000), .ACK_US(400)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pwm_clk(pwm_clk), .rc_en_in(rc_en_in), .cpu_ack(cpu_ack),
    .sel_rc(sel_rc), .failsafe(failsafe), .auto_req(auto_req), .ack_err(ack_err),
    .mode(mode), .mode_irq(mode_irq), .pulse_width(pulse_width), .width_valid(width_valid)
  );

  always #5 clk = ~clk;

  initial begin
    pwm_clk = 1'b0;
    forever begin
      @(negedge clk);
      pcnt = pcnt + 1;
      pwm_clk = (pcnt % div == 0);
    end
  end

  always @(negedge clk) begin
    if (mode_irq) irq_cnt++;
    if (ack_err) ackerr_cnt++;
    if (width_valid) wv_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // High for exactly w ticks: rise is placed before a non-tick edge.
  task automatic pulse(input int w);
    @(negedge clk); #1;
    while (pwm_clk) begin @(negedge clk); #1; end
    rc_en_in = 1'b1;
    cycles(2 * w);
    rc_en_in = 1'b0;
    cycles(20);
  endtask

  task automatic wait_mode(input string tag, input logic [1:0] m, input int budget);
    int n = 0;
    while (mode !== m && n < budget) begin @(negedge clk); n++; end
    #1;
    chk(tag, 32'(mode), 32'(m));
  endtask

  initial begin
    rst_n = 1'b0; rc_en_in = 1'b0; cpu_ack = 1'b0;
    cycles(4);
    chk("rst_mode", 32'(mode), 32'(M_FS));
    chk("rst_failsafe", 32'(failsafe), 1);
    chk("rst_sel_rc", 32'(sel_rc), 0);
    chk("rst_auto_req", 32'(auto_req), 0);
    chk("rst_pw", 32'(pulse_width), 0);
    chk("rst_flags", {29'd0, width_valid, ack_err, mode_irq}, 0);
    rst_n = 1'b1;
    cycles(4);

    // 1: FAILSAFE -> RC on three high pulses
    i0 = irq_cnt; w0 = wv_cnt;
    pulse(95); pulse(95);
    chk("t1_still_fs", 32'(mode), 32'(M_FS));
    pulse(95);
    chk("t1_mode_rc", 32'(mode), 32'(M_RC));
    chk("t1_sel_rc", 32'(sel_rc), 1);
    chk("t1_failsafe", 32'(failsafe), 0);
    chk("t1_pw", 32'(pulse_width), 95);
    chk("t1_irq", 32'(irq_cnt - i0), 1);
    chk("t1_wv", 32'(wv_cnt - w0), 3);

    // 2: RC -> TO_AUTO -> AUTO with cpu_ack
    i0 = irq_cnt;
    pulse(55); pulse(55); pulse(55);
    chk("t2_mode_to", 32'(mode), 32'(M_TO));
    chk("t2_auto_req", 32'(auto_req), 1);
    chk("t2_sel_rc", 32'(sel_rc), 1);
    chk("t2_pw", 32'(pulse_width), 55);
    cpu_ack = 1'b1;
    cycles(3);
    chk("t2_mode_auto", 32'(mode), 32'(M_AUTO));
    chk("t2_sel_rc0", 32'(sel_rc), 0);
    chk("t2_irq", 32'(irq_cnt - i0), 2);
    cpu_ack = 1'b0;

    // 3: ack timeout, then abort by a high pulse
    pulse(95); pulse(95); pulse(95);
    chk("t3_rc", 32'(mode), 32'(M_RC));
    pulse(55); pulse(55); pulse(55);
    a0 = ackerr_cnt;
    cycles(720);
    chk("t3_before_to", 32'(mode), 32'(M_TO));
    chk("t3_no_err_yet", 32'(ackerr_cnt - a0), 0);
    wait_mode("t3_timeout_rc", M_RC, 200);
    chk("t3_ack_err", 32'(ackerr_cnt - a0), 1);
    chk("t3_sel_rc", 32'(sel_rc), 1);
    pulse(55); pulse(55); pulse(55);
    chk("t3b_to", 32'(mode), 32'(M_TO));
    i0 = irq_cnt;
    pulse(95);
    chk("t3b_abort", 32'(mode), 32'(M_RC));
    chk("t3b_irq", 32'(irq_cnt - i0), 1);

    // 4: band inherits HIGH; an interleaved LOW blocks the override
    pulse(55); pulse(55); pulse(55);
    cpu_ack = 1'b1; cycles(3); cpu_ack = 1'b0;
    chk("t4_auto", 32'(mode), 32'(M_AUTO));
    pulse(95); pulse(75);
    chk("t4_band_wait", 32'(mode), 32'(M_AUTO));
    pulse(95);
    chk("t4_band_rc", 32'(mode), 32'(M_RC));
    pulse(55); pulse(55); pulse(55);
    cpu_ack = 1'b1; cycles(3); cpu_ack = 1'b0;
    pulse(95); pulse(55); pulse(95);
    chk("t4_stay_auto", 32'(mode), 32'(M_AUTO));
    pulse(70);
    chk("t4_lo_edge", 32'(mode), 32'(M_AUTO));
    pulse(80); pulse(110);
    chk("t4_hi_edge_wait", 32'(mode), 32'(M_AUTO));
    pulse(80);
    chk("t4_hi_edge_rc", 32'(mode), 32'(M_RC));

    // 5: cpu_ack ignored in RC; stuck-low then stuck-high loss
    cpu_ack = 1'b1; cycles(5); cpu_ack = 1'b0;
    chk("t5_ack_ignored", 32'(mode), 32'(M_RC));
    cycles(1600);
    chk("t5_before_loss", 32'(mode), 32'(M_RC));
    wait_mode("t5_low_loss", M_FS, 800);
    chk("t5_failsafe", 32'(failsafe), 1);
    chk("t5_sel_rc", 32'(sel_rc), 0);
    pulse(95); pulse(95); pulse(95);
    chk("t5_rc_again", 32'(mode), 32'(M_RC));
    div = 1;
    @(negedge clk); #1;
    rc_en_in = 1'b1;
    wait_mode("t5_high_loss", M_FS, 1200);
    chk("t5_sel_rc_hi", 32'(sel_rc), 0);
    cycles(65000);
    rc_en_in = 1'b0;
    cycles(10);
    chk("t6_pw_sat", 32'(pulse_width), 32'h0000_FFFF);
    chk("t6_sat_fs", 32'(mode), 32'(M_FS));
    div = 2;

    // 6: illegal widths force failsafe from AUTO
    pulse(55); pulse(55); pulse(55);
    chk("t6_auto", 32'(mode), 32'(M_AUTO));
    pulse(25);
    chk("t6_pw25", 32'(pulse_width), 25);
    pulse(39);
    chk("t6_pw39", 32'(pulse_width), 39);
    pulse(111);
    chk("t6_pw111", 32'(pulse_width), 111);
    chk("t6_bad3_auto", 32'(mode), 32'(M_AUTO));
    pulse(25);
    chk("t6_bad4_fs", 32'(mode), 32'(M_FS));
    chk("t6_failsafe", 32'(failsafe), 1);

    // async reset in TO_AUTO
    pulse(95); pulse(95); pulse(95);
    pulse(55); pulse(55); pulse(55);
    chk("t6_to", 32'(mode), 32'(M_TO));
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("ar_mode", 32'(mode), 32'(M_FS));
    chk("ar_outs", {28'd0, sel_rc, failsafe, auto_req, ack_err}, 32'b0100);
    chk("ar_pw", 32'(pulse_width), 0);
    cycles(3);
    rst_n = 1'b1;
    cycles(3);
    chk("ar_after", 32'(mode), 32'(M_FS));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rc_mode_ctrl.md
Name: rc_mode_ctrl

Overview:
- Decides which source drives the servo output mux: RC pilot or autopilot (CPU). Decision is based on the RC enable PWM channel (14 ms period, 1.1–1.9 ms pulse).
- Adds over a single-threshold detector:
  - width sanity check;
  - hysteresis and N-pulse confirmation;
  - link-loss watchdog;
  - request/acknowledge handover to the CPU before control returns to the autopilot.
- Sits between the PWM input pins and the servo output mux select; the CPU side connects to the register/interrupt block.

Parameters:
- MIN_US, 800, shortest legal pulse width in µs
- MAX_US, 2200, longest legal pulse width in µs
- HI_TH, 1600, width ≥ HI_TH votes RC
- LO_TH, 1400, width ≤ LO_TH votes AUTO; widths between thresholds are the hysteresis band
- CONFIRM, 3, consecutive agreeing pulses needed to change state
- BAD_LIMIT, 4, consecutive illegal pulses forcing failsafe
- LOSS_US, 50000, µs without a rising edge means link lost
- ACK_US, 20000, µs the CPU has to acknowledge handover

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- pwm_clk  in  1  1 MHz tick, one clk cycle wide, synchronous to clk
- rc_en_in  in  1  raw PWM from receiver, asynchronous
- cpu_ack  in  1  level; autopilot accepts control
- sel_rc  out  1  1 = servo mux takes RC
- failsafe  out  1  RC link invalid
- auto_req  out  1  handover request to CPU
- ack_err  out  1  one-clk pulse, handover timed out
- mode  out  2  00 AUTO, 01 RC, 10 TO_AUTO, 11 FAILSAFE
- mode_irq  out  1  one-clk pulse on every mode change
- pulse_width  out  16  last measured width, µs
- width_valid  out  1  one-clk pulse when pulse_width updates

Behaviour:
- Reset state:
  - mode=FAILSAFE, failsafe=1, sel_rc=0, auto_req=0.
  - pulse_width=0; width_valid, ack_err and mode_irq low.
  - All counters 0.
- Input sync and edge detection:
  - rc_en_in passes through a 2-flop synchronizer.
  - Edges are detected on the synced signal against its delayed copy.
- Width counter:
  - Cleared in the rising-edge cycle.
  - Increments on each pwm_clk tick while the synced input is high; saturates at 0xFFFF.
- Width capture:
  - On a falling edge, pulse_width takes the counter value before any same-cycle increment.
  - width_valid pulses 3 clk after rc_en_in is first sampled low (2 sync + 1 edge).
- Classification, same cycle as width_valid:
  - ILLEGAL if width < MIN_US or > MAX_US.
  - Otherwise HIGH (≥ HI_TH), LOW (≤ LO_TH) or BAND.
  - BAND inherits the previous legal vote; after reset the previous vote is LOW.
- Counters:
  - agree_cnt: counts consecutive identical legal votes; resets to 1 when the vote changes; cleared by an ILLEGAL pulse; saturates at CONFIRM.
  - bad_cnt: counts consecutive ILLEGAL pulses; cleared by any legal pulse.
- Loss watchdog:
  - Counts pwm_clk ticks and is cleared on a rising edge.
  - Reaching LOSS_US raises loss, held until the next rising edge.
  - Covers both a stuck-high and a stuck-low input.
- FSM, updated the cycle after width_valid, or immediately on loss or timeout:
  - FAILSAFE → RC when agree_cnt reaches CONFIRM on HIGH votes; → AUTO when it reaches CONFIRM on LOW votes.
  - AUTO → RC on CONFIRM consecutive HIGH votes. Pilot override needs no handshake.
  - RC → TO_AUTO on CONFIRM consecutive LOW votes; auto_req=1.
  - TO_AUTO has sel_rc=1 and auto_req=1.
    - cpu_ack=1 → AUTO.
    - A HIGH vote → RC (abort).
    - ACK_US elapsed → RC with an ack_err pulse.
  - Any non-FAILSAFE state → FAILSAFE on loss or when bad_cnt reaches BAD_LIMIT.
  - Priority: loss/bad > cpu_ack > timeout > votes.
  - Each state entry clears agree_cnt.
- Outputs by mode:
  - sel_rc=1 in RC and TO_AUTO only.
  - failsafe=1 only in FAILSAFE.
  - auto_req=1 only in TO_AUTO.
  - mode_irq fires on every transition, including aborts.
- cpu_ack asserted outside TO_AUTO is ignored.

Decomposition:
- Package rc_pkg holds:
  - mode encoding constants (AUTO, RC, TO_AUTO, FAILSAFE);
  - vote encoding (LOW, HIGH, ILLEGAL);
  - default µs thresholds.
- Sub-module rc_pulse_meter holds:
  - synchronizer and edge detection;
  - width counter;
  - loss watchdog.
  - Its outputs are pulse_width, width_valid and loss.
- rc_mode_ctrl holds classification, the counters and the FSM.

Test Plan:
1. Reset, then 3 pulses of 1900 µs → FAILSAFE→RC after the third falling edge; sel_rc=1, failsafe=0, mode=01, one mode_irq.
2. In RC, 3 pulses of 1100 µs → TO_AUTO with auto_req=1; cpu_ack=1 → AUTO, sel_rc=0, two mode_irq pulses total.
3. In TO_AUTO, no cpu_ack for 20 ms → ack_err pulse, back to RC with sel_rc=1. Repeat, inserting one 1900 µs pulse instead → immediate abort to RC.
4. In AUTO, pulses 1900, 1500, 1900 µs → RC after the third pulse (band inherits HIGH). Pulses 1900, 1100, 1900 µs → stays AUTO.
5. In RC, rc_en_in held low for 50 ms → FAILSAFE; sel_rc=0, failsafe=1. Repeat with the input held high.
6. In AUTO, 4 pulses of 500 µs → FAILSAFE. Also pulse_width=0xFFFF after a 70 ms high. Also assert rst_n mid-TO_AUTO → outputs return to reset values asynchronously.
